// File: rtl/mseq_tx_ctrl.sv
// Frame controller for the spread-spectrum transmitter: takes one byte per frame,
// reloads the m-sequence generator, then spreads preamble ones and the byte MSB-first.
module mseq_tx_ctrl #(
  parameter int   SEQ_LEN       = 31,
  parameter int   PREAMBLE_BITS = 2,
  parameter logic IDLE_LEVEL    = 1'b0
) (
  input  logic       CLK_50MHZ,
  input  logic       RST,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  input  logic       gen_chip,
  output logic       gen_load,
  output logic       gen_en,
  output logic       out_fun,
  output logic       busy,
  output logic       frame_done,
  output logic [4:0] chip_cnt,
  output logic [3:0] bit_idx
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    PREAMBLE = 3'd2,
    DATA     = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam logic [4:0] CHIP_LAST = 5'(SEQ_LEN - 1);
  localparam logic [3:0] PRE_LAST  = 4'(PREAMBLE_BITS - 1);
  localparam logic [3:0] BIT_LAST  = 4'(PREAMBLE_BITS + 7);

  state_t     state_reg, state_next;
  logic [7:0] shift_reg, shift_next;
  logic [4:0] chip_reg, chip_next;
  logic [3:0] bit_reg, bit_next;
  logic       out_reg, out_next;
  logic       chip_wrap;
  logic       spread_bit;

  assign chip_wrap = (chip_reg == CHIP_LAST);

  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      state_reg <= IDLE;
      shift_reg <= 8'd0;
      chip_reg  <= 5'd0;
      bit_reg   <= 4'd0;
      out_reg   <= IDLE_LEVEL;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      chip_reg  <= chip_next;
      bit_reg   <= bit_next;
      out_reg   <= out_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    chip_next  = chip_reg;
    bit_next   = bit_reg;
    out_next   = IDLE_LEVEL;
    data_ready = 1'b0;
    gen_load   = 1'b0;
    gen_en     = 1'b0;
    frame_done = 1'b0;
    busy       = 1'b1;
    spread_bit = 1'b1;

    case (state_reg)
      IDLE: begin
        data_ready = 1'b1;
        busy       = 1'b0;
        if (data_valid) begin
          shift_next = data_in;
          chip_next  = 5'd0;
          bit_next   = 4'd0;
          state_next = LOAD;
        end
      end

      LOAD: begin
        gen_load   = 1'b1;
        state_next = (PREAMBLE_BITS == 0) ? DATA : PREAMBLE;
      end

      PREAMBLE, DATA: begin
        gen_en     = 1'b1;
        spread_bit = (state_reg == DATA) ? shift_reg[7] : 1'b1;
        out_next   = gen_chip ^ ~spread_bit;
        if (chip_wrap) begin
          chip_next = 5'd0;
          bit_next  = bit_reg + 4'd1;
          if (state_reg == DATA) begin
            shift_next = {shift_reg[6:0], 1'b0};
            if (bit_reg == BIT_LAST) begin
              // Counters park at zero so bit_idx never leaves its documented range.
              bit_next   = 4'd0;
              state_next = DONE;
            end
          end else if (bit_reg == PRE_LAST) begin
            state_next = DATA;
          end
        end else begin
          chip_next = chip_reg + 5'd1;
        end
      end

      DONE: begin
        frame_done = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign out_fun  = out_reg;
  assign chip_cnt = chip_reg;
  assign bit_idx  = bit_reg;

endmodule

// File: tb/tb_mseq_tx_ctrl.sv
// Directed bench for mseq_tx_ctrl with a behavioural 5-bit LFSR generator
// (x^5+x^3+1 family, seed 00001) attached to a default build and a no-preamble build.
module tb_mseq_tx_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] data_in, data_in0;
  logic       data_valid, data_valid0;
  logic       data_ready, data_ready0;
  logic       gen_chip, gen_chip0;
  logic       gen_load, gen_load0;
  logic       gen_en, gen_en0;
  logic       out_fun, out_fun0;
  logic       busy, busy0;
  logic       frame_done, frame_done0;
  logic [4:0] chip_cnt, chip_cnt0;
  logic [3:0] bit_idx, bit_idx0;

  mseq_tx_ctrl dut (
    .CLK_50MHZ (clk),
    .RST       (rst),
    .data_in   (data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .gen_chip  (gen_chip),
    .gen_load  (gen_load),
    .gen_en    (gen_en),
    .out_fun   (out_fun),
    .busy      (busy),
    .frame_done(frame_done),
    .chip_cnt  (chip_cnt),
    .bit_idx   (bit_idx)
  );

  mseq_tx_ctrl #(.PREAMBLE_BITS(0)) dut0 (
    .CLK_50MHZ (clk),
    .RST       (rst),
    .data_in   (data_in0),
    .data_valid(data_valid0),
    .data_ready(data_ready0),
    .gen_chip  (gen_chip0),
    .gen_load  (gen_load0),
    .gen_en    (gen_en0),
    .out_fun   (out_fun0),
    .busy      (busy0),
    .frame_done(frame_done0),
    .chip_cnt  (chip_cnt0),
    .bit_idx   (bit_idx0)
  );

  // Generator models: chip is the oldest register bit, reload to seed on gen_load.
  logic [4:0] lfsr = 5'b00001;
  logic [4:0] lfsr0 = 5'b00001;
  assign gen_chip  = lfsr[4];
  assign gen_chip0 = lfsr0[4];
  always @(posedge clk) begin
    if (gen_load) lfsr <= 5'b00001;
    else if (gen_en) lfsr <= {lfsr[3:0], lfsr[4] ^ lfsr[2]};
    if (gen_load0) lfsr0 <= 5'b00001;
    else if (gen_en0) lfsr0 <= {lfsr0[3:0], lfsr0[4] ^ lfsr0[2]};
  end

  // Event monitors (cumulative; the test reads deltas).
  int cyc = 0, load_cnt = 0, done_cnt = 0, busy_cnt = 0, hs_cnt = 0, hs_last = 0, hs_prev = 0;
  int load0_cnt = 0, done0_cnt = 0, busy0_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (gen_load) load_cnt <= load_cnt + 1;
    if (frame_done) done_cnt <= done_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    if (data_valid && data_ready) begin
      hs_cnt  <= hs_cnt + 1;
      hs_last <= cyc;
      hs_prev <= hs_last;
    end
    if (gen_load0) load0_cnt <= load0_cnt + 1;
    if (frame_done0) done0_cnt <= done0_cnt + 1;
    if (busy0) busy0_cnt <= busy0_cnt + 1;
  end

  int   n_checks = 0;
  int   n_fail = 0;
  logic ref_seq [0:30];
  logic cap     [0:309];

  typedef struct {
    logic [7:0] data;
    logic [9:0] bits;
  } vec_t;
  vec_t vecs [4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // One full frame on the default build. With hold=1, data_valid stays high and
  // data_in moves to next_d right after the handshake.
  task automatic do_frame(input logic [7:0] d, input logic [9:0] bits,
                          input bit hold, input logic [7:0] next_d);
    int l0, d0, b0, cnt_err;
    logic [30:0] got, exp;
    data_in    = d;
    data_valid = 1'b1;
    for (int t = 0; t < 400 && !data_ready; t++) step();
    check($sformatf("ready_wait_%02h", d), data_ready, 1'b1);
    l0 = load_cnt; d0 = done_cnt; b0 = busy_cnt;
    step();  // E+1: LOAD
    if (hold) data_in = next_d;
    else data_valid = 1'b0;
    check($sformatf("load_%02h", d), {gen_load, gen_en, busy, data_ready}, 4'b1010);
    step();  // E+2: first spreading cycle
    check($sformatf("spread_start_%02h", d), {gen_load, gen_en}, 2'b01);
    cnt_err = 0;
    for (int k = 0; k < 310; k++) begin
      if (chip_cnt !== 5'(k % 31) || bit_idx !== 4'(k / 31)) cnt_err++;
      step();
      cap[k] = out_fun;
    end
    check($sformatf("counters_%02h", d), 64'(cnt_err), 64'd0);
    check($sformatf("done_pulse_%02h", d), {frame_done, gen_en, busy}, 3'b101);
    step();  // E+313: back in IDLE
    check($sformatf("idle_after_%02h", d), {out_fun, data_ready, busy, frame_done}, 4'b0100);
    check($sformatf("load_count_%02h", d), 64'(load_cnt - l0), 64'd1);
    check($sformatf("done_count_%02h", d), 64'(done_cnt - d0), 64'd1);
    check($sformatf("busy_cycles_%02h", d), 64'(busy_cnt - b0), 64'd312);
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 31; j++) begin
        got[j] = cap[i * 31 + j];
        exp[j] = ref_seq[j] ^ ~bits[9 - i];
      end
      check($sformatf("chips_%02h_bit%0d", d, i), 64'(got), 64'(exp));
    end
  endtask

  initial begin
    logic [4:0] r;
    int h0, d0, l0, b0;
    logic [30:0] got, exp;

    r = 5'b00001;
    for (int j = 0; j < 31; j++) begin
      ref_seq[j] = r[4];
      r = {r[3:0], r[4] ^ r[2]};
    end
    vecs[0] = '{data: 8'hA5, bits: 10'b11_1010_0101};
    vecs[1] = '{data: 8'h00, bits: 10'b11_0000_0000};
    vecs[2] = '{data: 8'hFF, bits: 10'b11_1111_1111};
    vecs[3] = '{data: 8'h3C, bits: 10'b11_0011_1100};

    // Reset and idle behaviour
    rst = 1'b1; data_in = 8'h00; data_valid = 1'b0; data_in0 = 8'h00; data_valid0 = 1'b0;
    step(); step(); step();
    rst = 1'b0;
    check("reset_state", {out_fun, data_ready, busy, gen_en, gen_load, frame_done}, 6'b010000);
    check("reset_counters", {chip_cnt, bit_idx}, 9'd0);
    d0 = done_cnt;
    for (int t = 0; t < 100; t++) step();
    check("idle_no_done", 64'(done_cnt - d0), 64'd0);
    check("idle_out", {out_fun, busy}, 2'b00);

    // Table-driven frames
    foreach (vecs[v]) do_frame(vecs[v].data, vecs[v].bits, 1'b0, 8'h00);

    // Held data_valid: 0x00 then 0xFF back to back
    h0 = hs_cnt;
    do_frame(8'h00, 10'b11_0000_0000, 1'b1, 8'hFF);
    do_frame(8'hFF, 10'b11_1111_1111, 1'b0, 8'h00);
    check("held_gap", 64'(hs_last - hs_prev), 64'd313);
    for (int t = 0; t < 50; t++) step();
    check("held_consumed", 64'(hs_cnt - h0), 64'd2);

    // Mid-frame reset at chip 150
    d0 = done_cnt;
    data_in = 8'h5A; data_valid = 1'b1;
    for (int t = 0; t < 400 && !data_ready; t++) step();
    step();
    data_valid = 1'b0;
    step();
    for (int k = 0; k < 150; k++) step();
    check("mid_chip150", {bit_idx, chip_cnt}, {4'd4, 5'd26});
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_reset_state", {out_fun, gen_en, busy, data_ready}, 4'b0001);
    check("mid_reset_counters", {chip_cnt, bit_idx}, 9'd0);
    for (int t = 0; t < 40; t++) step();
    check("mid_no_done", 64'(done_cnt - d0), 64'd0);
    do_frame(8'h96, 10'b11_1001_0110, 1'b0, 8'h00);

    // No-preamble build: 0x80 gives one true bit then seven inverted bits
    l0 = load0_cnt; d0 = done0_cnt; b0 = busy0_cnt;
    data_in0 = 8'h80; data_valid0 = 1'b1;
    for (int t = 0; t < 400 && !data_ready0; t++) step();
    check("p0_ready_wait", data_ready0, 1'b1);
    step();
    data_valid0 = 1'b0;
    check("p0_load", {gen_load0, gen_en0}, 2'b10);
    step();
    check("p0_spread_start", {gen_load0, gen_en0, busy0}, 3'b011);
    for (int k = 0; k < 248; k++) begin
      step();
      cap[k] = out_fun0;
    end
    check("p0_done_pulse", frame_done0, 1'b1);
    step();
    check("p0_idle_after", {out_fun0, data_ready0, busy0}, 3'b010);
    check("p0_load_count", 64'(load0_cnt - l0), 64'd1);
    check("p0_busy_cycles", 64'(busy0_cnt - b0), 64'd250);
    check("p0_done_count", 64'(done0_cnt - d0), 64'd1);
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 31; j++) begin
        got[j] = cap[i * 31 + j];
        exp[j] = (i == 0) ? ref_seq[j] : ~ref_seq[j];
      end
      check($sformatf("p0_chips_bit%0d", i), 64'(got), 64'(exp));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mseq_tx_ctrl.md
# mseq_tx_ctrl

Frame controller that sequences the 31-chip m-sequence generator to transmit spread-spectrum bytes on `out_fun`. It accepts one byte per frame over a valid/ready handshake and reloads the generator at frame start. It then emits a preamble of all-one bits followed by the byte MSB-first, each bit spread over one full m-sequence period (bit 1 = sequence as generated, bit 0 = inverted). It sits between the byte source and the generator; the receive-side decoder and its `buff`/`data` path consume `out_fun` unchanged.

## Interface
- `SEQ_LEN`, 31, chips per bit (generator period); 2..31
- `PREAMBLE_BITS`, 2, number of leading 1-bits per frame; 0..7
- `IDLE_LEVEL`, 1'b0, `out_fun` level outside frames
- `CLK_50MHZ`  in  1  sole clock, all logic on rising edge
- `RST`  in  1  reset, synchronous, active-high
- `data_in`  in  8  byte to transmit
- `data_valid`  in  1  source offers `data_in`
- `data_ready`  out  1  controller accepts; transfer when `data_valid & data_ready` at an edge
- `gen_chip`  in  1  current chip from generator
- `gen_load`  out  1  one-cycle pulse: generator reloads its seed; chip 0 presented the next cycle
- `gen_en`  out  1  generator advances one chip at this edge
- `out_fun`  out  1  registered spread output
- `busy`  out  1  frame in progress (state ≠ IDLE)
- `frame_done`  out  1  one-cycle pulse after last chip
- `chip_cnt`  out  5  chip index within current bit, 0..SEQ_LEN-1
- `bit_idx`  out  4  bit index within frame, 0..PREAMBLE_BITS+7

## Operation
- FSM states: IDLE, LOAD, PREAMBLE, DATA, DONE.
- IDLE: `data_ready`=1. On handshake, latch `data_in` into shift register, clear counters, go to LOAD. Otherwise stay.
- LOAD: one cycle, `gen_load`=1, `gen_en`=0. Go to PREAMBLE, or to DATA if `PREAMBLE_BITS`=0.
- PREAMBLE/DATA: `gen_en`=1 every cycle. Spread bit `b`: preamble uses 1, DATA uses shift-register MSB. Next `out_fun` = `gen_chip ^ ~b`.
- `chip_cnt` increments every cycle and wraps SEQ_LEN-1 → 0. On wrap, `bit_idx` increments; in DATA, the shift register shifts left by one.
- PREAMBLE → DATA when the wrap occurs with `bit_idx`=PREAMBLE_BITS-1.
- DATA → DONE when the wrap occurs with `bit_idx`=PREAMBLE_BITS+7.
- DONE: one cycle, `frame_done`=1, `gen_en`=0, next `out_fun`=IDLE_LEVEL. Go to IDLE.
- The controller never reloads the generator mid-frame. Sequence alignment relies on the generator period equalling SEQ_LEN.
- `data_valid` outside IDLE is ignored; the byte is not consumed.
- Reset (any state, including mid-frame): next edge gives state=IDLE, `out_fun`=IDLE_LEVEL, `gen_load`=0, `gen_en`=0, `frame_done`=0, `busy`=0, `chip_cnt`=0, `bit_idx`=0, shift register 0. `data_ready`=1 from the first cycle after reset. No partial frame resumes.

## Timing
- `out_fun` is registered: the chip combined in cycle t appears in cycle t+1.
- Handshake edge E. Cycle E+1 is LOAD. Cycle E+2 is the first PREAMBLE cycle (chip 0). Chip 0 drives `out_fun` from E+3.
- Frame length is (PREAMBLE_BITS+8)·SEQ_LEN chips (310 default). These occupy `out_fun` in cycles E+3 .. E+2+310.
- `frame_done` is high in the cycle after the last spreading cycle. `out_fun` returns to IDLE_LEVEL in the following cycle.
- Minimum handshake spacing is frame length + 3 cycles (LOAD, DONE, IDLE). `data_ready` is high for at least one cycle between frames.
- `data_ready`, `busy`, `gen_load` and `gen_en` decode combinationally from the state register. `frame_done` is also state-decoded.

## Test plan
Reference generator model for the bench: 5-bit LFSR x^5+x^3+1, seed 5'b00001, period 31.
- Reset idle: hold RST 3 cycles, release → `out_fun`=0, `data_ready`=1, `busy`=0, `gen_en`=0, no `frame_done` for 100 cycles.
- Single frame 0xA5:
  - Handshake → exactly one `gen_load` pulse one cycle later; `busy` high for 312 cycles.
  - Chips 0–61 equal the model sequence twice.
  - Chips 62+ follow bit pattern 1,0,1,0,0,1,0,1: each bit is the model sequence or its inverse.
  - `frame_done` pulses once; `out_fun`=0 afterward.
- Held `data_valid` with 0x00 then 0xFF: exactly two bytes consumed; the gap between handshakes equals 313 cycles.
  - The 0x00 frame data chips are the inverse of the model sequence.
  - The 0xFF frame data chips equal the model sequence.
- Counter wrap: monitor `chip_cnt` → sequence 0..30, wraps to 0. `bit_idx` runs 0..9 and increments only on wrap.
- Mid-frame reset: assert RST at chip 150 of a frame → next cycle IDLE, `out_fun`=0, `gen_en`=0. No `frame_done`. A new handshake gives a full fresh 310-chip frame starting with `gen_load`.
- `PREAMBLE_BITS`=0 build: byte 0x80 → LOAD then DATA directly; 248 chips; the first 31 chips equal the model sequence and the rest are inverted.
